// File: rtl/pixel_readout_sched.sv
// Row-by-row readout sequencer: round-robin row pick, column arbiter drive,
// one (row, column) event per grant with a per-pixel acknowledge pulse.
module pixel_readout_sched #(
  parameter int unsigned ROWS    = 4,
  parameter int unsigned COLS    = 4,
  parameter int unsigned ROW_ADD = 2,
  parameter int unsigned COL_ADD = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic [ROWS*COLS-1:0] pix_req_i,
  output logic                 col_refresh_o,
  output logic                 col_enable_o,
  output logic [COLS-1:0]      col_req_o,
  input  logic [COLS-1:0]      col_gnt_i,
  input  logic [COL_ADD-1:0]   col_add_i,
  output logic                 evt_valid_o,
  input  logic                 evt_ready_i,
  output logic [ROW_ADD-1:0]   evt_xadd_o,
  output logic [COL_ADD-1:0]   evt_yadd_o,
  output logic [ROWS*COLS-1:0] pix_ack_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int unsigned NPIX   = ROWS * COLS;
  localparam int unsigned PIX_AW = (NPIX > 1) ? $clog2(NPIX) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ROW_SEL  = 3'd1;
  localparam logic [2:0] S_COL_STEP = 3'd2;
  localparam logic [2:0] S_COL_WAIT = 3'd3;
  localparam logic [2:0] S_EMIT     = 3'd4;
  localparam logic [2:0] S_ROW_DONE = 3'd5;

  logic [2:0]         r_state;
  logic [COLS-1:0]    r_row_snap;
  logic [ROW_ADD-1:0] r_last_row;
  logic [ROW_ADD-1:0] r_xadd;
  logic [COL_ADD-1:0] r_yadd;
  logic               r_err;
  logic               r_col_refresh;
  logic               r_col_enable;
  logic [COLS-1:0]    r_col_req;
  logic               r_evt_valid;
  logic               r_busy;

  logic [2:0]         w_state_nxt;
  logic [COLS-1:0]    w_snap_nxt;
  logic [ROW_ADD-1:0] w_last_row_nxt;
  logic [ROW_ADD-1:0] w_xadd_nxt;
  logic [COL_ADD-1:0] w_yadd_nxt;
  logic               w_err_nxt;
  logic [NPIX-1:0]    w_pix_ack;
  logic [ROW_ADD-1:0] w_sel_row;
  logic               w_sel_found;

  // Round-robin search for the first requesting row after last_row
  always_comb begin
    w_sel_row   = ROW_ADD'((32'(r_last_row) + 32'd1) % ROWS);
    w_sel_found = 1'b0;
    for (int unsigned i = 1; i <= ROWS; i++) begin
      int unsigned idx;
      idx = (32'(r_last_row) + i) % ROWS;
      if (!w_sel_found && (|pix_req_i[idx*COLS +: COLS])) begin
        w_sel_row   = ROW_ADD'(idx);
        w_sel_found = 1'b1;
      end
    end
  end

  // Next-state and datapath updates
  always_comb begin
    w_state_nxt    = r_state;
    w_snap_nxt     = r_row_snap;
    w_last_row_nxt = r_last_row;
    w_xadd_nxt     = r_xadd;
    w_yadd_nxt     = r_yadd;
    w_err_nxt      = r_err;
    w_pix_ack      = '0;
    case (r_state)
      S_IDLE: begin
        if (enable_i && (|pix_req_i)) w_state_nxt = S_ROW_SEL;
      end
      S_ROW_SEL: begin
        w_xadd_nxt  = w_sel_row;
        w_snap_nxt  = pix_req_i[32'(w_sel_row)*COLS +: COLS];
        w_state_nxt = S_COL_STEP;
      end
      S_COL_STEP: begin
        w_state_nxt = S_COL_WAIT;
      end
      S_COL_WAIT: begin
        if (col_gnt_i == '0) begin
          w_state_nxt = S_ROW_DONE;
        end else if ($onehot(col_gnt_i) && (|(col_gnt_i & r_row_snap))) begin
          w_yadd_nxt  = col_add_i;
          w_snap_nxt  = r_row_snap & ~col_gnt_i;
          w_pix_ack[PIX_AW'(r_xadd) * PIX_AW'(COLS) + PIX_AW'(col_add_i)] = 1'b1;
          w_state_nxt = S_EMIT;
        end else begin
          // Grant outside the snapshot or not one-hot: arbiter out of step
          w_err_nxt   = 1'b1;
          w_state_nxt = S_ROW_DONE;
        end
      end
      S_EMIT: begin
        if (evt_ready_i) w_state_nxt = (|r_row_snap) ? S_COL_STEP : S_ROW_DONE;
      end
      S_ROW_DONE: begin
        w_last_row_nxt = r_xadd;
        w_snap_nxt     = '0;
        w_state_nxt    = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and registered outputs, decoded from the next state
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state       <= S_IDLE;
      r_row_snap    <= '0;
      r_last_row    <= ROW_ADD'(ROWS - 1);
      r_xadd        <= '0;
      r_yadd        <= '0;
      r_err         <= 1'b0;
      r_col_refresh <= 1'b0;
      r_col_enable  <= 1'b0;
      r_col_req     <= '0;
      r_evt_valid   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_row_snap    <= w_snap_nxt;
      r_last_row    <= w_last_row_nxt;
      r_xadd        <= w_xadd_nxt;
      r_yadd        <= w_yadd_nxt;
      r_err         <= w_err_nxt;
      r_col_refresh <= (w_state_nxt == S_ROW_SEL);
      r_col_enable  <= (w_state_nxt == S_COL_STEP);
      r_col_req     <= ((w_state_nxt == S_COL_STEP) || (w_state_nxt == S_COL_WAIT))
                       ? w_snap_nxt : '0;
      r_evt_valid   <= (w_state_nxt == S_EMIT);
      r_busy        <= (w_state_nxt != S_IDLE);
    end
  end

  assign col_refresh_o = r_col_refresh;
  assign col_enable_o  = r_col_enable;
  assign col_req_o     = r_col_req;
  assign evt_valid_o   = r_evt_valid;
  assign evt_xadd_o    = r_xadd;
  assign evt_yadd_o    = r_yadd;
  assign pix_ack_o     = w_pix_ack;
  assign busy_o        = r_busy;
  assign err_o         = r_err;

endmodule

// File: tb/tb_pixel_readout_sched.sv
// Bench for pixel_readout_sched: per-cycle vector table plus directed
// sequences for round-robin, async reset and arbiter protocol errors.
module tb_pixel_readout_sched;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        enable_i = 1'b0;
  logic [15:0] pix_req_i = '0;
  logic        col_refresh_o;
  logic        col_enable_o;
  logic [3:0]  col_req_o;
  logic [3:0]  col_gnt_i;
  logic [1:0]  col_add_i;
  logic        evt_valid_o;
  logic        evt_ready_i = 1'b0;
  logic [1:0]  evt_xadd_o;
  logic [1:0]  evt_yadd_o;
  logic [15:0] pix_ack_o;
  logic        busy_o;
  logic        err_o;

  int n_checks = 0;
  int n_fail   = 0;
  bit force_bad = 1'b0;

  always #5 clk_i = ~clk_i;

  pixel_readout_sched #(.ROWS(4), .COLS(4), .ROW_ADD(2), .COL_ADD(2)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i), .pix_req_i(pix_req_i),
    .col_refresh_o(col_refresh_o), .col_enable_o(col_enable_o), .col_req_o(col_req_o),
    .col_gnt_i(col_gnt_i), .col_add_i(col_add_i), .evt_valid_o(evt_valid_o),
    .evt_ready_i(evt_ready_i), .evt_xadd_o(evt_xadd_o), .evt_yadd_o(evt_yadd_o),
    .pix_ack_o(pix_ack_o), .busy_o(busy_o), .err_o(err_o)
  );

  // Column arbiter model: registered lowest-index grant on each step pulse
  function automatic logic [1:0] low_idx(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) if (v[i]) r = 2'(i);
    return r;
  endfunction

  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      col_gnt_i <= '0;
      col_add_i <= '0;
    end else if (col_refresh_o) begin
      col_gnt_i <= '0;
      col_add_i <= '0;
    end else if (col_enable_o) begin
      if (force_bad) begin
        col_gnt_i <= 4'b0100;
        col_add_i <= 2'd2;
      end else begin
        col_gnt_i <= col_req_o & (~col_req_o + 4'd1);
        col_add_i <= low_idx(col_req_o);
      end
    end
  end

  typedef struct {
    bit          en;
    logic [15:0] req;
    bit          rdy;
    bit          e_ref;
    bit          e_cen;
    logic [3:0]  e_creq;
    logic [15:0] e_ack;
    bit          e_val;
    logic [1:0]  e_x;
    logic [1:0]  e_y;
    bit          e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit en, logic [15:0] req, bit rdy, bit rf, bit cen,
                              logic [3:0] creq, logic [15:0] ack, bit val,
                              logic [1:0] x, logic [1:0] y, bit busy);
    vec_t v;
    v.en = en; v.req = req; v.rdy = rdy; v.e_ref = rf; v.e_cen = cen;
    v.e_creq = creq; v.e_ack = ack; v.e_val = val; v.e_x = x; v.e_y = y;
    v.e_busy = busy;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step=%0d got=0x%0h want=0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  initial begin
    int  nev;
    int  rows[4];
    int  exp_rows[4];
    bit  seen, sv, sa, sb, back;

    // Reset with arbitrary requests: every output low
    reset_i = 1'b1; enable_i = 1'b1; evt_ready_i = 1'b1; pix_req_i = 16'hA5C3;
    #12;
    check("rst_refresh", 0, 32'(col_refresh_o), 32'd0);
    check("rst_enable",  0, 32'(col_enable_o),  32'd0);
    check("rst_col_req", 0, 32'(col_req_o),     32'd0);
    check("rst_valid",   0, 32'(evt_valid_o),   32'd0);
    check("rst_xy",      0, 32'({evt_xadd_o, evt_yadd_o}), 32'd0);
    check("rst_ack",     0, 32'(pix_ack_o),     32'd0);
    check("rst_busy",    0, 32'(busy_o),        32'd0);
    check("rst_err",     0, 32'(err_o),         32'd0);
    enable_i = 1'b0; pix_req_i = 16'hFFFF;
    @(negedge clk_i);
    reset_i = 1'b0;

    // enable low keeps the sequencer idle
    repeat (3) vecs.push_back(mk(0, 16'hFFFF, 0, 0, 0, 4'h0, 16'h0, 0, 0, 0, 0));
    // Single pixel r2,c1
    vecs.push_back(mk(1, 16'h0200, 1, 0, 0, 4'h0,    16'h0000, 0, 0, 0, 0));
    vecs.push_back(mk(1, 16'h0200, 1, 1, 0, 4'h0,    16'h0000, 0, 0, 0, 1));
    vecs.push_back(mk(1, 16'h0200, 1, 0, 1, 4'b0010, 16'h0000, 0, 0, 0, 1));
    vecs.push_back(mk(1, 16'h0200, 1, 0, 0, 4'b0010, 16'h0200, 0, 0, 0, 1));
    vecs.push_back(mk(1, 16'h0000, 1, 0, 0, 4'h0,    16'h0000, 1, 2, 1, 1));
    vecs.push_back(mk(1, 16'h0000, 1, 0, 0, 4'h0,    16'h0000, 0, 0, 0, 1));
    vecs.push_back(mk(1, 16'h0000, 1, 0, 0, 4'h0,    16'h0000, 0, 0, 0, 0));
    // Row 1, cols 0 and 3, consumer stalls the first event for three cycles
    vecs.push_back(mk(1, 16'h0090, 0, 0, 0, 4'h0,    16'h0000, 0, 0, 0, 0));
    vecs.push_back(mk(1, 16'h0090, 0, 1, 0, 4'h0,    16'h0000, 0, 0, 0, 1));
    vecs.push_back(mk(1, 16'h0090, 0, 0, 1, 4'b1001, 16'h0000, 0, 0, 0, 1));
    vecs.push_back(mk(1, 16'h0090, 0, 0, 0, 4'b1001, 16'h0010, 0, 0, 0, 1));
    repeat (3) vecs.push_back(mk(1, 16'h0080, 0, 0, 0, 4'h0, 16'h0000, 1, 1, 0, 1));
    vecs.push_back(mk(1, 16'h0080, 1, 0, 0, 4'h0,    16'h0000, 1, 1, 0, 1));
    vecs.push_back(mk(1, 16'h0080, 1, 0, 1, 4'b1000, 16'h0000, 0, 0, 0, 1));
    vecs.push_back(mk(1, 16'h0080, 1, 0, 0, 4'b1000, 16'h0080, 0, 0, 0, 1));
    vecs.push_back(mk(1, 16'h0000, 1, 0, 0, 4'h0,    16'h0000, 1, 1, 3, 1));
    vecs.push_back(mk(1, 16'h0000, 1, 0, 0, 4'h0,    16'h0000, 0, 0, 0, 1));
    vecs.push_back(mk(1, 16'h0000, 1, 0, 0, 4'h0,    16'h0000, 0, 0, 0, 0));

    foreach (vecs[k]) begin
      @(posedge clk_i);
      #1;
      enable_i = vecs[k].en; pix_req_i = vecs[k].req; evt_ready_i = vecs[k].rdy;
      @(negedge clk_i);
      check("v_refresh", k, 32'(col_refresh_o), 32'(vecs[k].e_ref));
      check("v_enable",  k, 32'(col_enable_o),  32'(vecs[k].e_cen));
      check("v_col_req", k, 32'(col_req_o),     32'(vecs[k].e_creq));
      check("v_ack",     k, 32'(pix_ack_o),     32'(vecs[k].e_ack));
      check("v_valid",   k, 32'(evt_valid_o),   32'(vecs[k].e_val));
      check("v_busy",    k, 32'(busy_o),        32'(vecs[k].e_busy));
      if (vecs[k].e_val) begin
        check("v_xadd", k, 32'(evt_xadd_o), 32'(vecs[k].e_x));
        check("v_yadd", k, 32'(evt_yadd_o), 32'(vecs[k].e_y));
      end
    end
    check("v_err", 0, 32'(err_o), 32'd0);

    // Rows 0 and 2 requesting persistently: rows alternate 0,2,0,2
    enable_i = 1'b0; pix_req_i = '0;
    do_reset();
    enable_i = 1'b1; evt_ready_i = 1'b1; pix_req_i = 16'h0401;
    exp_rows = '{0, 2, 0, 2};
    rows = '{-1, -1, -1, -1};
    nev = 0;
    for (int c = 0; c < 200 && nev < 4; c++) begin
      @(negedge clk_i);
      if (evt_valid_o && evt_ready_i) begin
        rows[nev] = int'(evt_xadd_o);
        nev++;
      end
    end
    check("rr_events", 0, 32'(nev), 32'd4);
    for (int i = 0; i < 4; i++) check("rr_row", i, 32'(rows[i]), 32'(exp_rows[i]));

    // Asynchronous reset while an event is pending
    enable_i = 1'b0; pix_req_i = '0;
    do_reset();
    enable_i = 1'b1; evt_ready_i = 1'b0; pix_req_i = 16'h0040;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk_i);
      if (evt_valid_o) seen = 1'b1;
    end
    check("ar_valid_seen", 0, 32'(seen), 32'd1);
    #1 reset_i = 1'b1;
    #1;
    check("ar_valid_drop", 0, 32'(evt_valid_o), 32'd0);
    check("ar_busy_drop",  0, 32'(busy_o),      32'd0);
    @(negedge clk_i);
    pix_req_i = 16'h1001; evt_ready_i = 1'b1; reset_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk_i);
      if (evt_valid_o) seen = 1'b1;
    end
    check("ar_evt_seen", 0, 32'(seen), 32'd1);
    check("ar_first_row", 0, 32'(evt_xadd_o), 32'd0);
    check("ar_first_col", 0, 32'(evt_yadd_o), 32'd0);

    // Grant outside the row snapshot: sticky error, no event, no ack
    enable_i = 1'b0; pix_req_i = '0;
    do_reset();
    force_bad = 1'b1;
    enable_i = 1'b1; evt_ready_i = 1'b1; pix_req_i = 16'h0001;
    sv = 1'b0; sa = 1'b0; sb = 1'b0; back = 1'b0;
    for (int c = 0; c < 30 && !back; c++) begin
      @(negedge clk_i);
      if (evt_valid_o) sv = 1'b1;
      if (|pix_ack_o) sa = 1'b1;
      if (busy_o) sb = 1'b1;
      else if (sb) begin
        back = 1'b1;
        enable_i = 1'b0;
      end
    end
    check("er_idle_again", 0, 32'(back), 32'd1);
    check("er_no_event",   0, 32'(sv),   32'd0);
    check("er_no_ack",     0, 32'(sa),   32'd0);
    check("er_err_set",    0, 32'(err_o), 32'd1);
    force_bad = 1'b0;
    repeat (5) @(negedge clk_i);
    check("er_err_sticky", 0, 32'(err_o),  32'd1);
    check("er_busy_low",   0, 32'(busy_o), 32'd0);
    do_reset();
    check("er_err_clear",  0, 32'(err_o),  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
